hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer that owns all HI/LO updates produced by MULT, MULTU, DIV and DIVU.
- Accepts one operation from decode, runs a WIDTH-cycle shift-add multiply or restoring divide, then issues a single-cycle writeLoHi/writeData/writeDataHi write into the register file.
- Asserts stall to hold MFHI/MFLO reads until the pending result has landed.

Parameters:
- WIDTH, 32, operand and HI/LO word width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request a new operation; sampled on a rising edge.
- op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- srcA  input  WIDTH  rs value (multiplicand / dividend).
- srcB  input  WIDTH  rt value (multiplier / divisor).
- flush  input  1  synchronous cancel of any in-flight operation.
- hiloRead  input  1  decode is issuing MFHI/MFLO this cycle.
- busy  output  1  operation in flight (CALC or DONE).
- stall  output  1  hiloRead && busy.
- writeLoHi  output  1  one-cycle HI/LO write strobe to the register file.
- writeData  output  WIDTH  LO result (product low word / quotient).
- writeDataHi  output  WIDTH  HI result (product high word / remainder).

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, busy=0, writeLoHi=0, writeData=0, writeDataHi=0, internal operands cleared. An operation in flight at reset is discarded; no write occurs.
- States are IDLE, CALC and DONE.
- IDLE: on edge N with start=1 and flush=0, latch op, srcA and srcB.
  - Signed ops convert operands to magnitudes and record the sign of the result and of the dividend.
  - Go to CALC with counter=0.
  - start with flush=1 is ignored.
- CALC: perform one iteration per edge. Counter increments; at the edge that completes iteration WIDTH-1 (edge N+WIDTH), go to DONE.
  - Multiply: 2*WIDTH-bit shift-add on magnitudes.
  - Divide: restoring, one quotient bit per cycle.
- DONE: combinationally drive writeLoHi=(state==DONE)&&!flush, with final sign-corrected results on writeData/writeDataHi. The register file captures at edge N+WIDTH+1; state then returns to IDLE.
  - HI/LO latency is WIDTH+1 edges after the start edge. The next start is accepted at edge N+WIDTH+2 at the earliest.
- busy=1 exactly while state is CALC or DONE. start while busy is ignored, with no queueing; the pipeline must stall on busy.
- stall is combinational, so MFHI/MFLO proceeds in the first cycle after DONE and reads the new value.
- flush in CALC or DONE returns to IDLE at the next edge. A write in the DONE cycle is suppressed. flush has priority over start.
- Sign rules:
  - MULT product is negative iff operand signs differ; 2's-complement over 2*WIDTH bits.
  - DIV quotient is negative iff signs differ; the remainder takes the dividend's sign.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0 (natural wrap).
- Divide by zero, signed or unsigned: still takes full latency. Result is LO=all ones, HI=srcA raw.
- writeData/writeDataHi hold the last computed result outside DONE; they are valid only when writeLoHi=1.

Test Plan:
- Reset mid-CALC: start MULTU 0x00000002*0x00000003, assert rst at iteration 10 → busy=0 and writeLoHi stays 0 for WIDTH+5 cycles; a fresh op afterwards completes normally.
- MULTU 0xFFFFFFFF*0xFFFFFFFF → writeLoHi pulses exactly once, 33 edges after start; writeDataHi=0xFFFFFFFE, writeData=0x00000001; busy high for exactly 33 cycles.
- MULT -3*5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=0x0000000E, HI=0x00000002.
- DIVU 0x1234/0 → LO=0xFFFFFFFF, HI=0x00001234 after normal latency. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- hiloRead held from start → stall=1 for all 33 busy cycles and 0 in the cycle after writeLoHi. start pulsed mid-CALC → ignored, with exactly one write.
- flush during DONE → writeLoHi=0 in that cycle, state IDLE next. start+flush in IDLE → busy stays 0.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: iterative multiply/divide sequencer owning HI/LO updates.
// Accepts MULT/MULTU/DIV/DIVU, runs WIDTH shift-add or restoring-divide
// iterations, then issues a one-cycle HI/LO write to the register file.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   start, op           request and opcode (0=MULT 1=MULTU 2=DIV 3=DIVU)
//   srcA, srcB          rs / rt operands
//   flush               cancel any in-flight operation (priority over start)
//   hiloRead            decode is issuing MFHI/MFLO this cycle
//   busy, stall         operation in flight; MFHI/MFLO hold request
//   writeLoHi           one-cycle HI/LO write strobe
//   writeData/writeDataHi  LO / HI results
module hilo_muldiv_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  input  logic             hiloRead,
  output logic             busy,
  output logic             stall,
  output logic             writeLoHi,
  output logic [WIDTH-1:0] writeData,
  output logic [WIDTH-1:0] writeDataHi
);

  localparam int unsigned     PW        = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // r_p: {HI, LO} working register; product accumulator or {remainder, quotient}
  logic [PW-1:0]    r_p;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_raw_a;
  logic             r_is_div;
  logic             r_neg;
  logic             r_neg_dvd;
  logic             r_dz;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_sgn;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_mul_sum;
  logic [PW-1:0]    w_mul_next;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH+1:0] w_div_diff;
  logic [PW-1:0]    w_div_next;
  logic [PW-1:0]    w_p_iter;
  logic [PW-1:0]    w_prod_fin;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;
  logic [WIDTH-1:0] w_lo_fin;
  logic [WIDTH-1:0] w_hi_fin;

  // Operand decode: signed ops work on magnitudes
  assign w_accept = start && !flush;
  assign w_sgn    = !op[0];
  assign w_a_neg  = w_sgn && srcA[WIDTH-1];
  assign w_b_neg  = w_sgn && srcB[WIDTH-1];
  assign w_mag_a  = w_a_neg ? (~srcA + WIDTH'(1)) : srcA;
  assign w_mag_b  = w_b_neg ? (~srcB + WIDTH'(1)) : srcB;

  // Shift-add multiply step: multiplier sits in LO and shifts out LSB first
  assign w_mul_sum  = {1'b0, r_p[PW-1:WIDTH]} + (r_p[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_p[WIDTH-1:1]};

  // Restoring divide step: shift next dividend bit into the partial remainder
  assign w_div_shift = {r_p[PW-1:WIDTH], r_p[WIDTH-1]};
  assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_b};
  assign w_div_next  = w_div_diff[WIDTH+1]
                     ? {w_div_shift[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0}
                     : {w_div_diff[WIDTH-1:0],  r_p[WIDTH-2:0], 1'b1};

  assign w_p_iter = r_is_div ? w_div_next : w_mul_next;
  assign w_last   = (r_cnt == LAST_ITER);

  // Sign correction applied to the result of the final iteration
  assign w_prod_fin = r_neg ? (~w_p_iter + PW'(1)) : w_p_iter;
  assign w_q_fin    = r_neg ? (~w_p_iter[WIDTH-1:0] + WIDTH'(1)) : w_p_iter[WIDTH-1:0];
  assign w_r_fin    = r_neg_dvd ? (~w_p_iter[PW-1:WIDTH] + WIDTH'(1)) : w_p_iter[PW-1:WIDTH];

  // Divide by zero reports all-ones quotient and the raw dividend
  assign w_lo_fin = !r_is_div ? w_prod_fin[WIDTH-1:0] : (r_dz ? {WIDTH{1'b1}} : w_q_fin);
  assign w_hi_fin = !r_is_div ? w_prod_fin[PW-1:WIDTH] : (r_dz ? r_raw_a : w_r_fin);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    writeLoHi    = 1'b0;
    stall        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (flush)       w_state_next = S_IDLE;
        else if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        busy         = 1'b1;
        writeLoHi    = !flush;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    stall = hiloRead && busy;
  end

  // Datapath: operand capture, iteration, result latch on the final step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p         <= '0;
      r_b         <= '0;
      r_raw_a     <= '0;
      r_is_div    <= 1'b0;
      r_neg       <= 1'b0;
      r_neg_dvd   <= 1'b0;
      r_dz        <= 1'b0;
      r_cnt       <= '0;
      writeData   <= '0;
      writeDataHi <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_p       <= {{WIDTH{1'b0}}, w_mag_a};
            r_b       <= w_mag_b;
            r_raw_a   <= srcA;
            r_is_div  <= op[1];
            r_neg     <= w_a_neg ^ w_b_neg;
            r_neg_dvd <= w_a_neg;
            r_dz      <= op[1] && (srcB == '0);
            r_cnt     <= '0;
          end
        end
        S_CALC: begin
          if (!flush) begin
            r_p   <= w_p_iter;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              writeData   <= w_lo_fin;
              writeDataHi <= w_hi_fin;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Testbench for hilo_muldiv_ctrl: directed and randomized operations checked
// against an arithmetic reference model of MULT/MULTU/DIV/DIVU.
module tb_hilo_muldiv_ctrl;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] srcA;
  logic [W-1:0] srcB;
  logic         flush;
  logic         hiloRead;
  logic         busy;
  logic         stall;
  logic         writeLoHi;
  logic [W-1:0] writeData;
  logic [W-1:0] writeDataHi;

  int errors = 0;
  int checks = 0;

  hilo_muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .flush(flush), .hiloRead(hiloRead), .busy(busy), .stall(stall),
    .writeLoHi(writeLoHi), .writeData(writeData), .writeDataHi(writeDataHi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; C-style truncating division
  task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] lo, output logic [W-1:0] hi);
    longint           sa, sb, sp, sq, sr;
    logic [2*W-1:0]   up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: begin sp = sa * sb; lo = sp[W-1:0]; hi = sp[2*W-1:W]; end
      2'd1: begin up = {32'b0, a} * {32'b0, b}; lo = up[W-1:0]; hi = up[2*W-1:W]; end
      default: begin
        if (b == '0) begin
          lo = '1; hi = a;
        end else if (o == 2'd2) begin
          sq = sa / sb; sr = sa % sb; lo = sq[W-1:0]; hi = sr[W-1:0];
        end else begin
          lo = a / b; hi = a % b;
        end
      end
    endcase
  endtask

  // Issue one op, observe 40 cycles, check result, latency, busy/stall windows
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic hilo, input bit mid_start);
    logic [W-1:0] elo, ehi;
    logic [W-1:0] glo = 'x;
    logic [W-1:0] ghi = 'x;
    logic         stall_after = 1'bx;
    int done_k = 0, pulses = 0, busy_n = 0, stall_n = 0;
    model(o, a, b, elo, ehi);
    @(negedge clk);
    start = 1'b1; op = o; srcA = a; srcB = b; hiloRead = hilo;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy)  busy_n++;
      if (stall) stall_n++;
      if (k == LAT + 1) stall_after = stall;
      if (writeLoHi) begin
        pulses++;
        if (done_k == 0) begin done_k = k; glo = writeData; ghi = writeDataHi; end
      end
      start = mid_start && (k == 5);
      op    = 2'($urandom);
      srcA  = $urandom;
      srcB  = $urandom;
    end
    hiloRead = 1'b0;
    check({tag, " LO"}, glo, elo);
    check({tag, " HI"}, ghi, ehi);
    check({tag, " latency"}, W'(done_k), W'(LAT));
    check({tag, " pulses"}, W'(pulses), W'(1));
    check({tag, " busy cycles"}, W'(busy_n), W'(LAT));
    check({tag, " stall cycles"}, W'(stall_n), hilo ? W'(LAT) : W'(0));
    check({tag, " stall after"}, W'(stall_after), W'(0));
  endtask

  initial begin
    int cnt_b, cnt_w;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    // Reset state
    rst = 1'b1; start = 1'b0; flush = 1'b0; hiloRead = 1'b1;
    op = 2'd0; srcA = '0; srcB = '0;
    repeat (2) @(negedge clk);
    check("reset busy", W'(busy), W'(0));
    check("reset stall", W'(stall), W'(0));
    check("reset wlh", W'(writeLoHi), W'(0));
    check("reset LO", writeData, W'(0));
    check("reset HI", writeDataHi, W'(0));
    rst = 1'b0; hiloRead = 1'b0;

    // Directed operations
    run_op("MULTU max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("MULT -3*5", 2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b0);
    run_op("DIV -7/2", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
    run_op("DIVU 100/7", 2'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op("DIVU /0", 2'd3, 32'h0000_1234, 32'h0, 1'b0, 1'b0);
    run_op("DIV neg/0", 2'd2, 32'hFFFF_FF00, 32'h0, 1'b0, 1'b0);
    run_op("DIV ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("MULT mid-start", 2'd0, 32'h1234_5678, 32'h8765_4321, 1'b1, 1'b1);

    // Reset mid-CALC
    @(negedge clk);
    start = 1'b1; op = 2'd1; srcA = 32'd2; srcB = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst mid busy", W'(busy), W'(0));
    check("rst mid LO", writeData, W'(0));
    @(negedge clk);
    rst = 1'b0;
    cnt_b = 0; cnt_w = 0;
    for (int k = 0; k < W + 5; k++) begin
      @(negedge clk);
      if (busy) cnt_b++;
      if (writeLoHi) cnt_w++;
    end
    check("rst mid busy after", W'(cnt_b), W'(0));
    check("rst mid wlh after", W'(cnt_w), W'(0));
    run_op("MULTU after rst", 2'd1, 32'd2, 32'd3, 1'b0, 1'b0);

    // Flush during DONE
    @(negedge clk);
    start = 1'b1; op = 2'd1; srcA = 32'd9; srcB = 32'd9;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    #1;
    check("flush DONE wlh", W'(writeLoHi), W'(0));
    check("flush DONE busy", W'(busy), W'(1));
    @(negedge clk);
    flush = 1'b0;
    check("flush DONE idle", W'(busy), W'(0));

    // Flush during CALC
    @(negedge clk);
    start = 1'b1; op = 2'd2; srcA = 32'd50; srcB = 32'd5;
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush CALC idle", W'(busy), W'(0));
    cnt_w = 0;
    repeat (40) begin
      @(negedge clk);
      if (writeLoHi) cnt_w++;
    end
    check("flush CALC no write", W'(cnt_w), W'(0));

    // start with flush in IDLE is ignored
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'd1; srcA = 32'd1; srcB = 32'd1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    cnt_b = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) cnt_b++;
    end
    check("start+flush busy", W'(cnt_b), W'(0));

    // Randomized operations
    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
